// File: rtl/capture_sequencer_pkg.sv
// Shared types, widths and helpers for the camera capture sequencer.
package capture_sequencer_pkg;

    localparam int unsigned FRAME_W = 8;
    localparam int unsigned FIFO_W  = 9;
    localparam int unsigned WD_W    = 24;
    localparam int unsigned DRAIN_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_SINGLE  = 2'd0,
        MODE_NFRAMES = 2'd1,
        MODE_CONT    = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_t;

    // Frame target latched at start: only N-frame mode uses nframes, and 0 means 1.
    function automatic logic [FRAME_W-1:0] frameTarget(input mode_t mode,
                                                       input logic [FRAME_W-1:0] nframes);
        frameTarget = FRAME_W'(1);
        if (mode == MODE_NFRAMES && nframes != '0) begin
            frameTarget = nframes;
        end
    endfunction

endpackage

// File: rtl/capture_sequencer_vsync_sync_edge.sv
// Two-flop synchronizer with a registered rising-edge pulse; reusable for HREF.
module vsync_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic asyncIn,
    output logic edgePulse
);

    logic [2:0] syncQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncQ     <= '0;
            edgePulse <= 1'b0;
        end else begin
            syncQ     <= {syncQ[1:0], asyncIn};
            edgePulse <= syncQ[1] & ~syncQ[2];
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// Frame-level capture controller: starts the packetizer on a VSYNC boundary,
// runs 1/N/unlimited frames and aborts on host stop, FIFO overflow or camera stall.
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter logic [FIFO_W-1:0]  HIGH_WATER     = 9'd480,
    parameter logic [DRAIN_W-1:0] DRAIN_CYCLES   = 8'd64,
    parameter logic [WD_W-1:0]    TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_start,
    input  logic               cmd_stop,
    input  logic [1:0]         cmd_mode,
    input  logic [FRAME_W-1:0] cmd_nframes,
    input  logic               camera_vsync,
    input  logic [FIFO_W-1:0]  fifo_used,
    output logic               pkt_go,
    output logic               pkt_stop,
    output logic               busy,
    output logic               done,
    output logic [FRAME_W-1:0] frame_count,
    output logic               overflow_err,
    output logic               timeout_err
);

    state_t               state, stateNext;
    mode_t                modeQ;
    logic [FRAME_W-1:0]   targetQ;
    logic [WD_W-1:0]      wdCnt;
    logic [DRAIN_W-1:0]   drainCnt;
    logic                 abortCnt;
    logic                 vsEdge;
    logic                 acceptStart, setOverflow, setTimeout;
    logic                 frameFirst, frameInc, doneNext;

    vsync_sync_edge u_vsync (
        .clk      (clk),
        .rst_n    (rst_n),
        .asyncIn  (camera_vsync),
        .edgePulse(vsEdge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state plus one-cycle control strobes; abort causes are prioritised ahead of vsEdge.
    always_comb begin
        stateNext   = state;
        acceptStart = 1'b0;
        setOverflow = 1'b0;
        setTimeout  = 1'b0;
        frameFirst  = 1'b0;
        frameInc    = 1'b0;
        doneNext    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_start && !cmd_stop) begin
                    stateNext   = ST_SYNC;
                    acceptStart = 1'b1;
                end
            end
            ST_SYNC: begin
                if (cmd_stop) begin
                    stateNext = ST_ABORT;
                end else if (wdCnt == TIMEOUT_CYCLES) begin
                    stateNext  = ST_ABORT;
                    setTimeout = 1'b1;
                end else if (vsEdge) begin
                    stateNext  = ST_RUN;
                    frameFirst = 1'b1;
                end
            end
            ST_RUN: begin
                if (cmd_stop) begin
                    stateNext = ST_ABORT;
                end else if (fifo_used >= HIGH_WATER) begin
                    stateNext   = ST_ABORT;
                    setOverflow = 1'b1;
                end else if (wdCnt == TIMEOUT_CYCLES) begin
                    stateNext  = ST_ABORT;
                    setTimeout = 1'b1;
                end else if (vsEdge) begin
                    if (modeQ != MODE_CONT && frame_count == targetQ) begin
                        stateNext = ST_DRAIN;
                    end else begin
                        frameInc = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (cmd_stop) begin
                    stateNext = ST_ABORT;
                end else if (drainCnt == DRAIN_CYCLES - DRAIN_W'(1)) begin
                    stateNext = ST_IDLE;
                    doneNext  = 1'b1;
                end
            end
            ST_ABORT: begin
                if (abortCnt) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Counters, latched command and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modeQ        <= MODE_SINGLE;
            targetQ      <= '0;
            wdCnt        <= '0;
            drainCnt     <= '0;
            abortCnt     <= 1'b0;
            frame_count  <= '0;
            overflow_err <= 1'b0;
            timeout_err  <= 1'b0;
            pkt_go       <= 1'b0;
            pkt_stop     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (acceptStart || vsEdge) begin
                wdCnt <= '0;
            end else if ((state == ST_SYNC || state == ST_RUN) && wdCnt != '1) begin
                wdCnt <= wdCnt + WD_W'(1);
            end

            drainCnt <= (state == ST_DRAIN) ? drainCnt + DRAIN_W'(1) : '0;
            abortCnt <= (state == ST_ABORT);

            if (acceptStart) begin
                modeQ        <= mode_t'(cmd_mode);
                targetQ      <= frameTarget(mode_t'(cmd_mode), cmd_nframes);
                frame_count  <= '0;
                overflow_err <= 1'b0;
                timeout_err  <= 1'b0;
            end
            if (frameFirst) begin
                frame_count <= FRAME_W'(1);
            end else if (frameInc && frame_count != '1) begin
                frame_count <= frame_count + FRAME_W'(1);
            end
            if (setOverflow) begin
                overflow_err <= 1'b1;
            end
            if (setTimeout) begin
                timeout_err <= 1'b1;
            end

            pkt_go   <= (stateNext == ST_RUN);
            pkt_stop <= (stateNext == ST_ABORT);
            busy     <= (stateNext != ST_IDLE);
            done     <= doneNext;
        end
    end

endmodule
